// File: rtl/riscv_defines.sv
// riscv_defines: shared state, owner and width definitions for the core memory path
package riscv_defines;

    localparam int RISCV_ADDR_WIDTH = 32;

    typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_WAIT} arb_state_e;

    typedef enum logic {OWN_IF, OWN_LSU} arb_owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and LSU, one transaction at a time, LSU first
module mem_arbiter
    import riscv_defines::*;
#(
    parameter int ADDR_WIDTH = RISCV_ADDR_WIDTH,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req_i,
    input  logic [ADDR_WIDTH-1:0]   if_addr_i,
    output logic                    if_gnt_o,
    output logic                    if_rvalid_o,
    output logic [DATA_WIDTH-1:0]   if_rdata_o,
    output logic                    if_err_o,
    input  logic                    lsu_req_i,
    input  logic                    lsu_we_i,
    input  logic [DATA_WIDTH/8-1:0] lsu_be_i,
    input  logic [ADDR_WIDTH-1:0]   lsu_addr_i,
    input  logic [DATA_WIDTH-1:0]   lsu_wdata_i,
    output logic                    lsu_gnt_o,
    output logic                    lsu_rvalid_o,
    output logic [DATA_WIDTH-1:0]   lsu_rdata_o,
    output logic                    lsu_err_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic                    mem_err_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    output logic                    busy_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_e    r_state, w_state_nxt;
    arb_owner_e    r_owner, w_owner_nxt;
    logic [CW-1:0] r_cnt;
    logic          w_own_lsu, w_req, w_gnt, w_done, w_err;

    // Owner selection, bus mux, response routing and next-state; everything is forced low in reset
    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_own_lsu    = (r_state == ARB_IDLE) ? lsu_req_i : (r_owner == OWN_LSU);
        w_req        = !rst && (r_state != ARB_WAIT) && (w_own_lsu ? lsu_req_i : if_req_i);
        w_gnt        = w_req && mem_gnt_i;
        w_done       = !rst && (r_state == ARB_WAIT) && (mem_rvalid_i || r_cnt == CW'(TIMEOUT));
        w_err        = mem_rvalid_i ? mem_err_i : 1'b1;
        if (r_state == ARB_IDLE && w_req)
            w_owner_nxt = w_own_lsu ? OWN_LSU : OWN_IF;
        if (r_state != ARB_WAIT)
            w_state_nxt = w_gnt ? ARB_WAIT : (w_req ? ARB_REQ : ARB_IDLE);
        else if (w_done)
            w_state_nxt = ARB_IDLE;
        mem_req_o    = w_req;
        mem_we_o     = !rst && w_own_lsu && lsu_we_i;
        mem_be_o     = rst ? '0 : (w_own_lsu ? lsu_be_i : '1);
        mem_addr_o   = rst ? '0 : (w_own_lsu ? lsu_addr_i : if_addr_i);
        mem_wdata_o  = (rst || !w_own_lsu) ? '0 : lsu_wdata_i;
        if_gnt_o     = w_gnt && !w_own_lsu;
        lsu_gnt_o    = w_gnt && w_own_lsu;
        if_rvalid_o  = w_done && (r_owner == OWN_IF);
        lsu_rvalid_o = w_done && (r_owner == OWN_LSU);
        if_err_o     = if_rvalid_o && w_err;
        lsu_err_o    = lsu_rvalid_o && w_err;
        if_rdata_o   = rst ? '0 : mem_rdata_i;
        lsu_rdata_o  = rst ? '0 : mem_rdata_i;
        busy_o       = !rst && (r_state != ARB_IDLE);
    end

    // State, owner and response-timeout counter; the counter only runs while waiting for rvalid
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
            r_owner <= OWN_IF;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_cnt   <= (r_state == ARB_WAIT) ? r_cnt + 1'b1 : '0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios checked against a transaction-level model every cycle
module tb_mem_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0, lsu_req = 1'b0, lsu_we = 1'b0;
    logic [31:0] if_addr = '0, lsu_addr = '0, lsu_wdata = '0, mem_rdata = '0;
    logic [3:0]  lsu_be = '0;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0, mem_err = 1'b0;
    logic        if_gnt, if_rvalid, if_err, lsu_gnt, lsu_rvalid, lsu_err;
    logic [31:0] if_rdata, lsu_rdata, mem_addr, mem_wdata;
    logic        mem_req, mem_we, busy;
    logic [3:0]  mem_be;

    int checks = 0;
    int failures = 0;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt), .if_rvalid_o(if_rvalid),
        .if_rdata_o(if_rdata), .if_err_o(if_err),
        .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_be_i(lsu_be), .lsu_addr_i(lsu_addr),
        .lsu_wdata_i(lsu_wdata), .lsu_gnt_o(lsu_gnt), .lsu_rvalid_o(lsu_rvalid),
        .lsu_rdata_o(lsu_rdata), .lsu_err_o(lsu_err),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
        .mem_err_i(mem_err), .mem_rdata_i(mem_rdata), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: an open transaction has an owner, may be granted, and ages while granted
    logic m_open = 1'b0, m_lsu = 1'b0, m_granted = 1'b0;
    int   m_age = 0;

    function automatic logic offer_lsu();
        return m_open ? m_lsu : lsu_req;
    endfunction

    function automatic logic offered();
        if (m_open && m_granted) return 1'b0;
        return offer_lsu() ? lsu_req : if_req;
    endfunction

    function automatic logic finishing();
        return m_open && m_granted && (mem_rvalid || m_age >= TO);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_open <= 1'b0;
            m_granted <= 1'b0;
            m_age <= 0;
        end else if (!m_open) begin
            if (offered()) begin
                m_open <= 1'b1;
                m_lsu <= lsu_req;
                m_granted <= mem_gnt;
                m_age <= 0;
            end
        end else if (!m_granted) begin
            if (!offered()) m_open <= 1'b0;
            else if (mem_gnt) begin
                m_granted <= 1'b1;
                m_age <= 0;
            end
        end else if (finishing()) begin
            m_open <= 1'b0;
            m_granted <= 1'b0;
        end else m_age <= m_age + 1;
    end

    // Every cycle, compare DUT outputs against what the model says they must be
    always @(negedge clk) begin
        logic e_lsu, e_req, e_done;
        if (rst) begin
            chk("rst_ctrl", {mem_req, mem_we, if_gnt, lsu_gnt, if_rvalid, lsu_rvalid, if_err, lsu_err, busy}, '0);
            chk("rst_bus", {|mem_be, |mem_addr, |mem_wdata, |if_rdata, |lsu_rdata}, '0);
        end else begin
            e_lsu  = offer_lsu();
            e_req  = offered();
            e_done = finishing();
            chk("m_req", mem_req, e_req);
            chk("m_if_gnt", if_gnt, e_req && mem_gnt && !e_lsu);
            chk("m_lsu_gnt", lsu_gnt, e_req && mem_gnt && e_lsu);
            chk("m_if_rvalid", if_rvalid, e_done && !m_lsu);
            chk("m_lsu_rvalid", lsu_rvalid, e_done && m_lsu);
            chk("m_busy", busy, m_open);
            if (e_req) begin
                chk("m_addr", mem_addr, e_lsu ? lsu_addr : if_addr);
                chk("m_we", mem_we, e_lsu && lsu_we);
                chk("m_be", mem_be, e_lsu ? lsu_be : 4'hf);
                chk("m_wdata", mem_wdata, e_lsu ? lsu_wdata : 32'h0);
            end
            if (e_done) begin
                chk("m_err", m_lsu ? lsu_err : if_err, mem_rvalid ? mem_err : 1'b1);
                chk("m_rdata", m_lsu ? lsu_rdata : if_rdata, mem_rvalid ? mem_rdata : (m_lsu ? lsu_rdata : if_rdata));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic g, input logic rv, input logic er, input logic [31:0] d);
        mem_gnt = g;
        mem_rvalid = rv;
        mem_err = er;
        mem_rdata = d;
    endtask

    initial begin
        mem_rdata = 32'hA5A5_A5A5;
        @(negedge clk);
        chk("reset_outputs", {mem_req, busy, if_rdata}, '0);
        cyc();
        rst = 1'b0;
        bus(0, 0, 0, 0);
        // IF-only read at 0x100
        if_req = 1; if_addr = 32'h100; bus(1, 0, 0, 0);
        @(negedge clk);
        chk("t1_if_gnt", if_gnt, 1);
        chk("t1_addr", mem_addr, 32'h100);
        chk("t1_be_we", {mem_be, mem_we}, 5'b11110);
        cyc();
        if_req = 0; bus(0, 1, 0, 32'hDEADBEEF);
        @(negedge clk);
        chk("t1_if_rvalid", if_rvalid, 1);
        chk("t1_if_rdata", if_rdata, 32'hDEADBEEF);
        chk("t1_lsu_quiet", {lsu_gnt, lsu_rvalid, lsu_err}, 0);
        cyc();
        bus(0, 0, 0, 0);
        @(negedge clk);
        chk("t1_idle", busy, 0);
        cyc();
        // Simultaneous requests: LSU write wins, IF follows after the response
        if_req = 1; if_addr = 32'h104;
        lsu_req = 1; lsu_we = 1; lsu_be = 4'b0001; lsu_addr = 32'h200; lsu_wdata = 32'h55;
        bus(1, 0, 0, 0);
        @(negedge clk);
        chk("t2_lsu_gnt", {lsu_gnt, if_gnt}, 2'b10);
        chk("t2_fields", {mem_addr, mem_wdata}, {32'h200, 32'h55});
        chk("t2_we_be", {mem_we, mem_be}, 5'b10001);
        cyc();
        lsu_req = 0; lsu_we = 0; bus(0, 1, 0, 0);
        @(negedge clk);
        chk("t2_lsu_rvalid", {lsu_rvalid, if_rvalid, if_gnt}, 3'b100);
        cyc();
        bus(1, 0, 0, 0);
        @(negedge clk);
        chk("t2_if_next", {if_gnt, busy}, 2'b10);
        chk("t2_if_addr", mem_addr, 32'h104);
        cyc();
        if_req = 0; bus(0, 1, 0, 32'h0BAD_F00D);
        @(negedge clk);
        chk("t2_if_rvalid", if_rvalid, 1);
        cyc();
        bus(0, 0, 0, 0);
        cyc();
        // IF owner keeps the bus while LSU arrives during a delayed grant
        if_req = 1; if_addr = 32'h300;
        @(negedge clk);
        chk("t3_req", {mem_req, if_gnt}, 2'b10);
        cyc();
        lsu_req = 1; lsu_addr = 32'h400; lsu_be = 4'hf;
        @(negedge clk);
        chk("t3_hold1", {mem_addr, 31'h0, lsu_gnt}, {32'h300, 32'h0});
        cyc();
        @(negedge clk);
        chk("t3_hold2", mem_addr, 32'h300);
        cyc();
        bus(1, 0, 0, 0);
        @(negedge clk);
        chk("t3_if_gnt", {if_gnt, lsu_gnt}, 2'b10);
        cyc();
        if_req = 0; bus(0, 0, 0, 0);
        @(negedge clk);
        chk("t3_wait", {mem_req, lsu_gnt}, 0);
        cyc();
        bus(0, 1, 0, 32'h1111);
        @(negedge clk);
        chk("t3_if_rvalid", {if_rvalid, lsu_gnt}, 2'b10);
        cyc();
        bus(1, 0, 0, 0);
        @(negedge clk);
        chk("t3_lsu_gnt", {lsu_gnt, mem_addr}, {1'b1, 32'h400});
        cyc();
        lsu_req = 0; bus(0, 1, 0, 32'h2222);
        @(negedge clk);
        chk("t3_lsu_rvalid", lsu_rvalid, 1);
        cyc();
        bus(0, 0, 0, 0);
        // Timeout with no response, then with rvalid on the timeout cycle
        for (int r = 0; r < 2; r++) begin
            cyc();
            lsu_req = 1; lsu_addr = 32'h600; bus(1, 0, 0, 0);
            @(negedge clk);
            chk("t4_gnt", lsu_gnt, 1);
            cyc();
            lsu_req = 0; bus(0, 0, 0, 0);
            for (int k = 0; k < TO; k++) begin
                @(negedge clk);
                chk("t4_no_rvalid", lsu_rvalid, 0);
                cyc();
            end
            if (r == 1) bus(0, 1, 0, 32'h12345678);
            @(negedge clk);
            chk("t4_rvalid", lsu_rvalid, 1);
            chk("t4_err", lsu_err, r == 0);
            if (r == 1) chk("t4_rdata", lsu_rdata, 32'h12345678);
            cyc();
            bus(0, 0, 0, 0);
            @(negedge clk);
            chk("t4_idle", busy, 0);
        end
        // Reset during WAIT discards the transaction
        cyc();
        lsu_req = 1; lsu_addr = 32'h500; bus(1, 0, 0, 0);
        cyc();
        rst = 1; bus(1, 0, 0, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("t5_rst_out", {mem_req, lsu_gnt, busy, lsu_rvalid}, 0);
        chk("t5_rst_rdata", lsu_rdata, 0);
        cyc();
        rst = 0; lsu_req = 0; bus(0, 1, 0, 32'h3333);
        @(negedge clk);
        chk("t5_no_rvalid", {lsu_rvalid, if_rvalid, busy}, 0);
        cyc();
        bus(0, 0, 0, 0);
        // LSU withdraws before grant
        lsu_req = 1; lsu_addr = 32'h700;
        @(negedge clk);
        chk("t6_req", {mem_req, lsu_gnt}, 2'b10);
        cyc();
        lsu_req = 0;
        @(negedge clk);
        chk("t6_abort", {busy, mem_req}, 2'b10);
        cyc();
        bus(0, 1, 0, 0);
        @(negedge clk);
        chk("t6_idle", {busy, mem_req, lsu_rvalid}, 0);
        cyc();
        bus(0, 0, 0, 0);
        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
